// File: rtl/shift_reg_feeder_pkg.sv
// ----------------------------------------------------------------------------
// feeder_pkg
//   Shared types and constants for the shift_reg_feeder control stage.
//   state_t  : feeder FSM state encoding
//   MODE_PAR : in_mode value requesting a one-cycle parallel load
//   MODE_SER : in_mode value requesting a WIDTH-cycle serial shift, MSB first
// ----------------------------------------------------------------------------
package feeder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } state_t;

   localparam logic MODE_PAR = 1'b0;
   localparam logic MODE_SER = 1'b1;

endpackage

// File: rtl/shift_reg_feeder_if.sv
// ----------------------------------------------------------------------------
// shift_reg_feeder_if
//   Valid/ready word handshake between a word source and shift_reg_feeder.
//   in_valid : source offers a word
//   in_ready : feeder can accept a word
//   in_data  : word to deliver (WIDTH bits)
//   in_mode  : 0 = parallel load, 1 = serial shift; sampled with in_data
//   master   : source side
//   slave    : feeder side
// ----------------------------------------------------------------------------
interface shift_reg_feeder_if #(
   parameter int unsigned WIDTH = 4
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_mode;

   modport master (
      output in_valid,
      output in_data,
      output in_mode,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_mode,
      output in_ready
   );

endinterface

// File: rtl/shift_reg_feeder.sv
// ----------------------------------------------------------------------------
// shift_reg_feeder
//   Upstream control stage for a negedge-clocked 4-bit universal shift
//   register (parallel load / serial shift, no hold mode). Accepts words over
//   a valid/ready handshake and delivers each one either as a one-cycle
//   parallel load or as WIDTH serial shifts, MSB first. Between transfers it
//   keeps reloading the last delivered word so the downstream register holds.
//
//   CP     : clock; this block updates on posedge, downstream samples negedge
//   clr    : asynchronous active-low reset
//   bus    : word handshake (slave side): in_valid/in_ready/in_data/in_mode
//   Select : 1 = downstream parallel load from PI, 0 = shift in SI
//   SI     : serial bit to the downstream register
//   PI     : parallel word to the downstream register
//   busy   : a transfer is in progress
//   done   : one-cycle pulse when a transfer completes
// ----------------------------------------------------------------------------
module shift_reg_feeder
   import feeder_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             CP,
   input  logic             clr,
   shift_reg_feeder_if.slave bus,
   output logic             Select,
   output logic             SI,
   output logic [WIDTH-1:0] PI,
   output logic             busy,
   output logic             done
);

   localparam int unsigned      CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    cnt_inc;

   logic             sel_d;
   logic             si_d;
   logic [WIDTH-1:0] pi_d;
   logic             busy_d;
   logic             done_d;

   assign cnt_inc      = cnt_q + CW'(1);
   assign bus.in_ready = (state_q == IDLE);

   // Outputs are registered, so each branch computes the output values that
   // belong to the state being entered, not the state being left.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      sel_d   = 1'b1;
      si_d    = 1'b0;
      pi_d    = hold_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // in_ready is high throughout IDLE, so in_valid alone accepts
            if (bus.in_valid) begin
               data_d = bus.in_data;
               busy_d = 1'b1;
               if (bus.in_mode == MODE_PAR) begin
                  state_d = LOAD;
                  pi_d    = bus.in_data;
               end else begin
                  state_d = SHIFT;
                  cnt_d   = '0;
                  sel_d   = 1'b0;
                  si_d    = bus.in_data[WIDTH-1];
               end
            end
         end

         LOAD: begin
            hold_d  = data_q;
            state_d = DONE;
            pi_d    = data_q;
            done_d  = 1'b1;
         end

         SHIFT: begin
            cnt_d = cnt_inc;
            if (cnt_q == CNT_LAST) begin
               hold_d  = data_q;
               state_d = DONE;
               pi_d    = data_q;
               done_d  = 1'b1;
            end else begin
               // next bit out is the one for the incremented count
               sel_d  = 1'b0;
               si_d   = data_q[CNT_LAST - cnt_inc];
               busy_d = 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CP or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
         hold_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         Select  <= 1'b1;
         SI      <= 1'b0;
         PI      <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         Select  <= sel_d;
         SI      <= si_d;
         PI      <= pi_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

endmodule

// File: doc/shift_reg_feeder.md
Name: shift_reg_feeder

Overview:
- Upstream control stage for the 4-bit universal shift register (parallel load / serial shift, negedge-clocked).
- Accepts words over a valid/ready handshake and delivers each word into the shift register by one of two methods:
  - a one-cycle parallel load;
  - WIDTH serial shifts, MSB first.
- Between transfers it drives a parallel reload of the last delivered word, so the downstream register holds its contents. The downstream register has no hold mode, so this reload is what keeps it stable.

Parameters:
- WIDTH, 4, word width. Must match the downstream register width and be ≥ 2.

Ports:
- CP, input, 1, clock. The block updates on the posedge. The downstream register samples on the negedge, so all outputs are stable half a cycle before it samples.
- clr, input, 1, reset: asynchronous, active-low.
- in_valid, input, 1, source offers a word.
- in_ready, output, 1, block can accept a word.
- in_data, input, WIDTH, word to deliver.
- in_mode, input, 1: 0 = parallel load, 1 = serial shift. Sampled with in_data.
- Select, output, 1, to the shift register: 1 = parallel load from PI, 0 = shift in SI.
- SI, output, 1, serial bit to the shift register.
- PI, output, WIDTH, parallel word to the shift register.
- busy, output, 1, a transfer is in progress.
- done, output, 1, one-cycle pulse when a transfer completes.

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. All outputs except in_ready are registered.
- Registers: hold[WIDTH-1:0], data_q, cnt of clog2(WIDTH) bits.
- Reset (clr=0, async):
  - state=IDLE, hold=0, data_q=0, cnt=0.
  - Select=1, PI=0, SI=0, busy=0, done=0.
  - in_ready=1, because in_ready = (state==IDLE).
  - The downstream register therefore clears on its next negedge.
- IDLE:
  - Outputs: Select=1, PI=hold, SI=0, busy=0.
  - On posedge with in_valid & in_ready: data_q<=in_data, then
    - in_mode=0 → go to LOAD;
    - in_mode=1 → go to SHIFT with cnt=0.
- LOAD (1 cycle):
  - Outputs: Select=1, PI=data_q, busy=1.
  - hold<=data_q. Then go to DONE.
- SHIFT (exactly WIDTH cycles):
  - Outputs: Select=0, SI=data_q[WIDTH-1-cnt], busy=1.
  - cnt increments every cycle.
  - When cnt==WIDTH-1: hold<=data_q, go to DONE.
  - After WIDTH downstream negedges, the downstream register holds data_q with bit order preserved.
- DONE (1 cycle):
  - Outputs: Select=1, PI=hold, SI=0, done=1, busy=0.
  - Then go to IDLE. in_ready stays 0 during DONE.
- Latency, counted from the accepting edge k:
  - parallel load: done is high in cycle k+2; a new accept is possible at edge k+3;
  - serial: SHIFT occupies cycles k+1..k+WIDTH, done is high in cycle k+WIDTH+1, a new accept is possible at edge k+WIDTH+2.
- Handshake rules:
  - in_valid while in_ready=0 is ignored; the source holds in_data and in_mode stable until accepted.
  - in_data changes after acceptance have no effect on the word in flight.
- Reset mid-transfer: the transfer is aborted immediately and all reset values apply. No done pulse is produced, and hold=0 (not the partial word).
- Select is never X and never glitches outside the posedge.
- The block never leaves Select=0 outside SHIFT, so the downstream register never shifts unintended bits.

Decomposition:
- Shared package feeder_pkg:
  - state enum {IDLE, LOAD, SHIFT, DONE};
  - constants MODE_PAR=1'b0, MODE_SER=1'b1.
- No sub-module is required. The bit counter and mux are inline. A single module of roughly 150–200 lines is sufficient.

Test Plan:
- Reset: pulse clr low mid-cycle → all outputs take reset values immediately (no clock needed), and the downstream Out reads 0000 after the next negedge.
- Parallel load: in_data=4'b1010, in_mode=0, accepted at edge k → Select=1 and PI=1010 in cycle k+1; done=1 in cycle k+2; downstream Out=1010 and holds 1010 for 10 further idle cycles.
- Serial shift: in_data=4'b1011, in_mode=1 → Select=0 and SI=1,0,1,1 in cycles k+1..k+4; done=1 in cycle k+5; downstream Out=1011 and holds it.
- Back-to-back with in_valid held high: serial 0110 then parallel 1001 → second accept at edge k+6; in_ready=0 from k+1 to k+5; Out=0110, then Out=1001.
- Busy-ignore: toggle in_data to 1111 during the SHIFT of 0011 → the delivered word is 0011, and in_ready stays 0 until IDLE.
- Abort: clr low during the third SHIFT cycle of 1101 → no done pulse; Select=1, PI=0; Out=0000 after the next negedge; the next transfer of 0101 completes normally.
